// File: rtl/uart_tx_frame.sv
// UART transmitter: 8N1 frames LSB first at a switch-selected baud rate.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_frame #(
    parameter int DIV_9600   = 5208,
    parameter int DIV_57600  = 868,
    parameter int DIV_115200 = 434
) (
    input  logic       src_clk,
    input  logic       rst,
    input  logic [1:0] baud_sel,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int DIV_A   = (DIV_9600 > DIV_57600) ? DIV_9600 : DIV_57600;
    localparam int DIV_MAX = (DIV_A > DIV_115200) ? DIV_A : DIV_115200;
    localparam int CW      = $clog2(DIV_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] div_q, div_d;
    logic [CW-1:0] div_sel;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    bit_nxt;
    logic [7:0]    shift_q, shift_d;
    logic          tx_d, busy_d, done_d;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    always_comb begin
        unique case (baud_sel)
            2'b01:   div_sel = CW'(DIV_57600);
            2'b10:   div_sel = CW'(DIV_115200);
            default: div_sel = CW'(DIV_9600);
        endcase
    end

    assign bit_end = (cnt_q == div_q - CW'(1));
    assign bit_nxt = bit_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx;
        busy_d  = busy;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    shift_d = tx_data;
                    div_d   = div_sel;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                    state_d = START;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = shift_q[bit_nxt];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge src_clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= CW'(DIV_9600);
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
            busy    <= busy_d;
            tx_done <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
